// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, byte width and default baud divisor.
package uart_pkg;

    localparam int unsigned DATA_W           = 8;
    localparam int unsigned BAUD_DIV_DEFAULT = 5208;

    typedef logic [DATA_W-1:0] uart_byte_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered full/empty/level and first-word-fallthrough read data.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned LW    = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok, pop_ok;

    // Full is the registered flag, so a push while full is dropped even if a pop happens too.
    always_comb begin
        push_ok  = push && !full_q;
        pop_ok   = pop && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            level_d = level_q + LW'(1);
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - LW'(1);
        end
        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = level_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: FIFO-fed serializer with a flop-driven TXD line.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT,
    parameter int unsigned FIFO_AW  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] WrData,
    input  logic              WrEn,
    output logic              Full,
    output logic [FIFO_AW:0]  Level,
    output logic              Busy,
    output logic              TXD
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam int unsigned BIT_W = $clog2(DATA_W);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
    uart_byte_t       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             fifo_pop;
    logic             fifo_empty;
    uart_byte_t       fifo_rd_data;
    logic             bit_done;

    sync_fifo #(
        .WIDTH (DATA_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push    (WrEn),
        .wr_data (WrData),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (Full),
        .empty   (fifo_empty),
        .level   (Level)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        bit_done  = (cnt_q == CNT_W'(BAUD_DIV - 1));

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_rd_data;
`endif
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    if (bit_idx_q == BIT_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Chain straight into the next start bit when more data is waiting.
                if (bit_done) begin
                    cnt_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^fifo_rd_data;
`endif
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Line level follows the current state one clock later, keeping TXD a pure flop.
        case (state_q)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_d = parity_q;
`endif
            default:   txd_d = 1'b1;
        endcase

        // A pop always leaves the FSM busy, so next occupancy only matters for pushes.
        busy_d = (state_d != ST_IDLE) || !fifo_empty || (WrEn && !Full);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign TXD  = txd_q;
    assign Busy = busy_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered (BAUD_DIV=4, FIFO_AW=2); follows UART_TX_PARITY_EN.
module tb_uart_tx_buffered;

    localparam int BD = 4;
    localparam int AW = 2;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CLK = NBITS * BD;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic [AW:0]   level;
    logic          busy;
    logic          txd;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    uart_tx_buffered #(
        .BAUD_DIV (BD),
        .FIFO_AW  (AW)
    ) dut (
        .CLK    (clk),
        .RST    (rst),
        .WrData (wr_data),
        .WrEn   (wr_en),
        .Full   (full),
        .Level  (level),
        .Busy   (busy),
        .TXD    (txd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b);
        wr_data = b;
        wr_en   = 1'b1;
        cyc();
        wr_en   = 1'b0;
    endtask

    // Entered just after the edge that shows clock k0 of the frame's start bit on TXD.
    task automatic frame(input logic [7:0] b, input logic busy_end, input int k0);
        logic exp_bit;
        int   idx;
        for (int k = k0; k < FRAME_CLK; k++) begin
            idx = k / BD;
            if (idx == 0)              exp_bit = 1'b0;
            else if (idx <= 8)         exp_bit = b[idx-1];
            else if (idx == NBITS - 1) exp_bit = 1'b1;
            else                       exp_bit = ^b;
            check($sformatf("txd_%02h_k%0d", b, k), 32'(txd), 32'(exp_bit));
            if (k == FRAME_CLK - 2) check("busy_pre_end", 32'(busy), 32'd1);
            if (k == FRAME_CLK - 1) check("busy_end", 32'(busy), 32'(busy_end));
            cyc();
        end
    endtask

    task automatic idle_watch(input string tag, input int n);
        int lows = 0;
        for (int i = 0; i < n; i++) begin
            if (txd !== 1'b1) lows++;
            cyc();
        end
        check(tag, 32'(lows), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;

        // Reset then idle
        repeat (3) cyc();
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            check("idle_txd", 32'(txd), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_level", 32'(level), 32'd0);
            check("idle_full", 32'(full), 32'd0);
        end

        // Single byte: written at N, popped at N+1, start bit at N+2
        wr(8'hA5);
        check("a5_lvl_n", 32'(level), 32'd1);
        check("a5_busy_n", 32'(busy), 32'd1);
        check("a5_txd_n", 32'(txd), 32'd1);
        cyc();
        check("a5_lvl_n1", 32'(level), 32'd0);
        check("a5_txd_n1", 32'(txd), 32'd1);
        check("a5_busy_n1", 32'(busy), 32'd1);
        cyc();
        frame(8'hA5, 1'b0, 0);
        check("a5_after_txd", 32'(txd), 32'd1);
        check("a5_after_busy", 32'(busy), 32'd0);
        idle_watch("a5_idle_lows", 5);

        // Back-to-back frames, no idle gap
        wr(8'h55);
        wr(8'h0F);
        check("b2b_level", 32'(level), 32'd1);
        cyc();
        frame(8'h55, 1'b1, 0);
        frame(8'h0F, 1'b0, 0);
        check("b2b_after_busy", 32'(busy), 32'd0);
        idle_watch("b2b_idle_lows", 5);

        // Overflow: 0x01 popped, 0x02..0x05 queued, 0x06 dropped
        wr(8'h01);
        wr(8'h02);
        wr(8'h03);
        wr(8'h04);
        check("ovf_full_before", 32'(full), 32'd0);
        wr(8'h05);
        check("ovf_full_at4", 32'(full), 32'd1);
        wr(8'h06);
        check("ovf_level", 32'(level), 32'd4);
        check("ovf_full", 32'(full), 32'd1);
        frame(8'h01, 1'b1, 3);
        check("ovf_level_after1", 32'(level), 32'd3);
        check("ovf_full_after1", 32'(full), 32'd0);
        frame(8'h02, 1'b1, 0);
        frame(8'h03, 1'b1, 0);
        frame(8'h04, 1'b1, 0);
        frame(8'h05, 1'b0, 0);
        check("ovf_level_end", 32'(level), 32'd0);
        idle_watch("ovf_no_06", 3 * FRAME_CLK);

        // Reset during data bit 3 of 0xFF with two bytes queued
        wr(8'hFF);
        wr(8'hAA);
        wr(8'hBB);
        check("mid_level", 32'(level), 32'd2);
        repeat (16) cyc();
        check("mid_bit3_txd", 32'(txd), 32'd1);
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mid_rst_txd", 32'(txd), 32'd1);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_full", 32'(full), 32'd0);
        idle_watch("mid_no_start", 3 * FRAME_CLK);
        check("mid_busy_later", 32'(busy), 32'd0);

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x07 -> 1, 0x03 -> 0
        wr(8'h07);
        cyc();
        cyc();
        frame(8'h07, 1'b0, 0);
        wr(8'h03);
        cyc();
        cyc();
        frame(8'h03, 1'b0, 0);
        check("par_busy_end", 32'(busy), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Buffered 8N1 UART transmitter: the PC-bound direction of the serial link.
- Design logic (SDRAM readback, VGA status, debug dumps) pushes bytes into an internal FIFO.
- The block serializes each byte onto TXD at a fixed baud rate with no CPU-style handshaking.
- Companion to the receive path: together they give full-duplex byte streaming to the host.

Parameters:
- BAUD_DIV, 5208, clocks per bit (50 MHz / 9600 baud); legal range ≥ 2.
- FIFO_AW, 4, FIFO address width; depth = 2^FIFO_AW = 16 entries.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  reset; synchronous, active-high.
- WrData  in  8  byte to enqueue.
- WrEn  in  1  enqueue strobe; accepted when WrEn=1 and Full=0.
- Full  out  1  FIFO holds 2^FIFO_AW bytes.
- Level  out  FIFO_AW+1  current FIFO occupancy, 0..2^FIFO_AW.
- Busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- TXD  out  1  serial output; idle level 1.

Behaviour:
- Reset (RST=1 at a posedge): TXD=1, Full=0, Level=0, Busy=0, FSM=IDLE, pointers=0, baud and bit counters=0.
- Reset mid-frame aborts the frame: TXD=1 from the next edge, and queued bytes are discarded.
- Write: when WrEn=1 and Full=0, WrData is stored at the posedge.
- Write while Full=1 is dropped silently; Level and contents are unchanged.
- Full is evaluated before any same-cycle pop, so a write while full is dropped even if a pop occurs that cycle.
- Level update rules:
  - write only: +1
  - pop only: −1
  - simultaneous write and pop: unchanged
- Pointers wrap modulo 2^FIFO_AW.
- FSM states:
  - IDLE: TXD=1. If Level>0, pop the head into shift register and go to START.
  - START: TXD=0 for BAUD_DIV clocks, then go to DATA with bit index=0.
  - DATA: TXD=shift[0] (LSB first) for BAUD_DIV clocks per bit. Shift right after each bit. After bit 7, go to PARITY (if enabled) or STOP.
  - STOP: TXD=1 for BAUD_DIV clocks. On the final clock, if Level>0, pop and go directly to START (zero-gap back-to-back); otherwise go to IDLE.
- Baud counter counts 0..BAUD_DIV−1. It is reset on every state entry, and a state advances when the counter equals BAUD_DIV−1.
- Latency: with an empty FIFO in IDLE, a write at edge N is popped at edge N+1, and TXD falls at edge N+2.
- Frame length is exactly 10·BAUD_DIV clocks (11·BAUD_DIV with parity).
- Busy = (FSM≠IDLE) or (Level≠0).
- TXD is driven directly from a flop: no glitches, no combinational path.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: PARITY state inserted between DATA and STOP; TXD = XOR of the 8 data bits (even parity) for BAUD_DIV clocks; frame becomes 8E1.
- Undefined: no PARITY state; frame is 8N1.

Decomposition:
- Shared package uart_pkg:
  - FSM state encodings (ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP)
  - default BAUD_DIV constant
  - 8-bit data width constant (also used by the receive path)
- One sub-module: sync_fifo (parameterised width/depth, synchronous reset, push/pop/full/empty/level).
  - Owns all FIFO boundary logic; the top level contains only the serializer FSM and baud counter.

Test Plan (bench uses BAUD_DIV=4, FIFO_AW=2):
- Reset then idle: RST high for 3 clocks, then low 20 clocks, no writes → TXD=1, Busy=0, Level=0, Full=0 throughout.
- Single byte: write 0xA5 at edge N → TXD=0 at N+2 for 4 clocks; then bits 1,0,1,0,0,1,0,1 at 4 clocks each; stop=1 for 4 clocks; Busy falls after the 40th clock of the frame.
- Back-to-back: write 0x55, 0x0F on consecutive cycles → second start bit begins the clock immediately after the first stop bit's 4th clock (no idle gap); sampled bytes equal 0x55, 0x0F.
- Overflow: with the FSM stalled mid-frame, write 0x01..0x06 on consecutive cycles → first byte is popped, 4 are queued, Full=1, Level=4, byte 0x06 dropped; line carries 0x01..0x05 only.
- Reset mid-frame: assert RST during data bit 3 of 0xFF with 2 bytes queued → next edge TXD=1, Level=0, Busy=0; no further start bits.
- Parity (UART_TX_PARITY_EN defined): send 0x07 → parity bit=1, frame 44 clocks; send 0x03 → parity bit=0.
